// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: branch redirect handshake, flush window and misaligned-target trap (BRANCH_STATS_EN adds taken/stall counters)
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_in,
  input  logic        stall_in,
  input  logic        imem_ready_in,
  output logic        redirect_valid_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out,
  output logic        busy_out,
  output logic        misaligned_out,
  output logic [31:0] misaligned_addr_out
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] taken_count_out,
  output logic [31:0] redirect_stall_count_out
`endif
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic take, go;
  assign take = state == IDLE && valid_in && branch_taken_in && !stall_in;
  assign go = take && target_in[1:0] == 2'b00;
  assign busy_out = state != IDLE;
  assign flush_out = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: state_nx = go ? REDIRECT : IDLE;
      REDIRECT: if (imem_ready_in) begin
        state_nx = FLUSH_CYCLES == 1 ? IDLE : FLUSH;
        cnt_nx = 4'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        state_nx = cnt == 4'd1 ? IDLE : FLUSH;
        cnt_nx = cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      redirect_valid_out <= 1'b0;
      redirect_pc_out <= '0;
      misaligned_out <= 1'b0;
      misaligned_addr_out <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      redirect_valid_out <= state_nx == REDIRECT;
      redirect_pc_out <= go ? target_in : redirect_pc_out;
      misaligned_out <= take && !go;
      misaligned_addr_out <= take && !go ? target_in : misaligned_addr_out;
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      taken_count_out <= '0;
      redirect_stall_count_out <= '0;
    end else begin
      taken_count_out <= taken_count_out + 32'(go);
      redirect_stall_count_out <= redirect_stall_count_out + 32'(state == REDIRECT && !imem_ready_in);
    end
  end
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: randomized and directed checks of three flush-window variants against a cycle model
module tb_branch_redirect_ctrl;
  logic clk = 1'b0;
  logic rst, valid, taken, stall, ready;
  logic [31:0] target;
  logic [2:0] rv, fl, bz, mi;
  logic [31:0] pc [3];
  logic [31:0] ma [3];
`ifdef BRANCH_STATS_EN
  logic [31:0] tk [3];
  logic [31:0] sc [3];
`endif
  int checks = 0;
  int passed = 0;
  bit m_pend [3];
  int m_left [3];
  bit m_mis [3];
  logic [31:0] m_pc [3];
  logic [31:0] m_ma [3];
  logic [31:0] m_tk [3];
  logic [31:0] m_st [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    branch_redirect_ctrl #(.FLUSH_CYCLES(g == 0 ? 2 : g == 1 ? 1 : 4)) dut (
      .clk_in(clk),
      .rst_in(rst),
      .valid_in(valid),
      .branch_taken_in(taken),
      .target_in(target),
      .stall_in(stall),
      .imem_ready_in(ready),
      .redirect_valid_out(rv[g]),
      .redirect_pc_out(pc[g]),
      .flush_out(fl[g]),
      .busy_out(bz[g]),
      .misaligned_out(mi[g]),
      .misaligned_addr_out(ma[g])
`ifdef BRANCH_STATS_EN
      ,
      .taken_count_out(tk[g]),
      .redirect_stall_count_out(sc[g])
`endif
    );
  end
  function automatic int fc(int i);
    return i == 0 ? 2 : i == 1 ? 1 : 4;
  endfunction
  function automatic logic [67:0] actv(int i);
    return {rv[i], fl[i], bz[i], mi[i], pc[i], ma[i]};
  endfunction
  function automatic logic [67:0] expv(int i);
    return {m_pend[i], m_pend[i] || m_left[i] > 0, m_pend[i] || m_left[i] > 0, m_mis[i], m_pc[i], m_ma[i]};
  endfunction
  task automatic drive(input logic r_st, input logic vv, input logic tt, input logic ss, input logic rr, input logic [31:0] tg);
    rst = r_st;
    valid = vv;
    taken = tt;
    stall = ss;
    ready = rr;
    target = tg;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pend[i] = 0;
        m_left[i] = 0;
        m_mis[i] = 0;
        m_pc[i] = '0;
        m_ma[i] = '0;
        m_tk[i] = '0;
        m_st[i] = '0;
      end else begin
        m_mis[i] = 0;
        if (m_pend[i]) begin
          if (!ready) m_st[i] = m_st[i] + 1;
          else begin
            m_pend[i] = 0;
            m_left[i] = fc(i) - 1;
          end
        end else if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
        else if (valid && taken && !stall) begin
          if (target % 4 != 0) begin
            m_mis[i] = 1;
            m_ma[i] = target;
          end else begin
            m_pend[i] = 1;
            m_pc[i] = target;
            m_tk[i] = m_tk[i] + 1;
          end
        end
      end
    end
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 1, 32'h0);
    for (int k = 0; k < 6; k++) step();
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 1, 0, 1, 32'h100);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== 68'h0) $display("FAIL reset inst%0d got %h want 0", i, actv(i));
        else passed++;
      end
    end
  endtask
  task automatic test_backpressure();
    idle();
    for (int k = 0; k < 6; k++) begin
      drive(0, k == 0, 1, 0, k >= 4, 32'h100);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) $display("FAIL backpressure_model inst%0d k%0d got %h want %h", i, k, actv(i), expv(i));
        else passed++;
      end
      checks++;
      if ({rv[0], fl[0], pc[0]} !== {k <= 3, k <= 4, 32'h100}) $display("FAIL backpressure k%0d got %b%b %h want %b%b 100", k, rv[0], fl[0], pc[0], k <= 3, k <= 4);
      else passed++;
    end
`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({tk[i], sc[i]} !== {32'd1, 32'd3}) $display("FAIL stats inst%0d got %0d/%0d want 1/3", i, tk[i], sc[i]);
      else passed++;
    end
`endif
  endtask
  task automatic test_aligned();
    idle();
    for (int k = 0; k < 4; k++) begin
      drive(0, k == 0, 1, 0, 1, 32'h100);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) $display("FAIL aligned_model inst%0d k%0d got %h want %h", i, k, actv(i), expv(i));
        else passed++;
      end
      checks++;
      if ({rv[0], fl[0], bz[0], pc[0]} !== {k == 0, k < 2, k < 2, 32'h100}) $display("FAIL aligned k%0d got %b%b%b %h want %b%b%b 100", k, rv[0], fl[0], bz[0], pc[0], k == 0, k < 2, k < 2);
      else passed++;
    end
  endtask
  task automatic test_misaligned();
    logic [31:0] tgs [4];
    tgs = '{32'h102, 32'h105, 32'h10b, 32'h10b};
    idle();
    for (int k = 0; k < 4; k++) begin
      drive(0, k < 3, 1, 0, 1, tgs[k]);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) $display("FAIL misaligned_model inst%0d k%0d got %h want %h", i, k, actv(i), expv(i));
        else passed++;
      end
      checks++;
      if ({rv[0], fl[0], bz[0], mi[0], ma[0]} !== {3'b000, k < 3, tgs[k]}) $display("FAIL misaligned k%0d got %b%b%b%b %h want 000%b %h", k, rv[0], fl[0], bz[0], mi[0], ma[0], k < 3, tgs[k]);
      else passed++;
    end
  endtask
  task automatic test_gating();
    idle();
    for (int k = 0; k < 7; k++) begin
      drive(0, k < 6, k != 0, k == 1, k >= 5, k < 2 ? 32'h300 : k == 2 ? 32'h100 : 32'h200);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) $display("FAIL gating_model inst%0d k%0d got %h want %h", i, k, actv(i), expv(i));
        else passed++;
      end
      checks++;
      if ({rv[0], bz[0]} !== {k >= 2 && k <= 4, k >= 2 && k <= 5} || (k >= 2 && pc[0] !== 32'h100)) $display("FAIL gating k%0d got %b%b %h want %b%b 100", k, rv[0], bz[0], pc[0], k >= 2 && k <= 4, k >= 2 && k <= 5);
      else passed++;
    end
  endtask
  task automatic test_reset_mid();
    logic [33:0] want [5];
    want = '{{2'b11, 32'h80}, {2'b01, 32'h80}, {2'b00, 32'h0}, {2'b11, 32'h40}, {2'b11, 32'h40}};
    idle();
    for (int k = 0; k < 5; k++) begin
      drive(k == 2, k == 0 || k == 3, 1, 0, k < 3, k == 0 ? 32'h80 : 32'h40);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) $display("FAIL reset_mid_model inst%0d k%0d got %h want %h", i, k, actv(i), expv(i));
        else passed++;
      end
      checks++;
      if ({rv[0], fl[0], pc[0]} !== want[k]) $display("FAIL reset_mid k%0d got %b%b %h want %h", k, rv[0], fl[0], pc[0], want[k]);
      else passed++;
`ifdef BRANCH_STATS_EN
      if (k == 2) begin
        checks++;
        if ({tk[0], sc[0]} !== 64'h0) $display("FAIL reset_mid_stats got %0d/%0d want 0/0", tk[0], sc[0]);
        else passed++;
      end
`endif
    end
  endtask
  task automatic test_flush_one();
    idle();
    for (int k = 0; k < 3; k++) begin
      drive(0, k == 0, 1, 0, 1, 32'h1000);
      step();
      checks++;
      if ({rv[1], fl[1], bz[1], pc[1]} !== {k == 0, k == 0, k == 0, 32'h1000}) $display("FAIL flush_one k%0d got %b%b%b %h want %b%b%b 1000", k, rv[1], fl[1], bz[1], pc[1], k == 0, k == 0, k == 0);
      else passed++;
    end
  endtask
  task automatic test_random();
    idle();
    for (int k = 0; k < 800; k++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0 ? $urandom : $urandom & 32'hffff_fffc);
      step();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (actv(i) !== expv(i)) $display("FAIL random inst%0d k%0d got %h want %h", i, k, actv(i), expv(i));
        else passed++;
`ifdef BRANCH_STATS_EN
        checks++;
        if ({tk[i], sc[i]} !== {m_tk[i], m_st[i]}) $display("FAIL random_stats inst%0d got %0d/%0d want %0d/%0d", i, tk[i], sc[i], m_tk[i], m_st[i]);
        else passed++;
`endif
      end
    end
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 32'h0);
    test_reset();
    test_backpressure();
    test_aligned();
    test_misaligned();
    test_gating();
    test_reset_mid();
    test_flush_one();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
